alu_pipe: RTL and testbench

- Parametrised, pipelined, signed two's-complement ALU; next generation of the 16-bit registered 4-op ALU used in the FIR datapath.
- Adds configurable width and fixed-point shift, saturation mode, a multiply-accumulate unit with an internal accumulator, status flags, and valid/ready handshakes on input and output.
- Sits between the FIR coefficient/sample sequencer and the result writeback; a MATLAB golden model checks it on the same vector files.

---
 rtl/alu_pipe_pkg.sv | 38 +++
 rtl/alu_sat.sv | 31 +++
 rtl/alu_pipe.sv | 138 +++++++++++++
 tb/tb_alu_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared op codes and the clamp/wrap helper for the pipelined ALU.
package alu_pipe_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD    = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 3'd1;
  localparam logic [OP_W-1:0] OP_AND    = 3'd2;
  localparam logic [OP_W-1:0] OP_OR     = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_MUL    = 3'd5;
  localparam logic [OP_W-1:0] OP_MAC    = 3'd6;
  localparam logic [OP_W-1:0] OP_CLRACC = 3'd7;

  // Widest value sat_trunc can take; callers sign-extend into it.
  localparam int SAT_MAXW = 128;

  typedef struct packed {
    logic                       ovf;
    logic signed [SAT_MAXW-1:0] val;
  } sat_t;

  function automatic sat_t sat_trunc(input logic signed [SAT_MAXW-1:0] value,
                                     input int width, input logic sat);
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    sat_t r;
    hi = $signed({SAT_MAXW{1'b1}} >> (SAT_MAXW - width + 1));
    lo = ~hi;
    r.ovf = (value > hi) || (value < lo);
    if (sat && (value > hi))
      r.val = hi;
    else if (sat && (value < lo))
      r.val = lo;
    else
      r.val = (value <<< (SAT_MAXW - width)) >>> (SAT_MAXW - width);
    return r;
  endfunction
endpackage

// File: rtl/alu_sat.sv
// Output conditioning: optional fixed-point shift, clamp or wrap, and status flags.
module alu_sat
  import alu_pipe_pkg::*;
#(
  parameter int IN_W  = 40,
  parameter int WIDTH = 16,
  parameter int FRAC  = 0,
  parameter int SAT   = 1
) (
  input  logic signed [IN_W-1:0]  value,
  input  logic                    do_shift,
  output logic signed [WIDTH-1:0] result,
  output logic                    flag_z,
  output logic                    flag_n,
  output logic                    flag_v
);
  logic signed [IN_W-1:0] shifted;
  sat_t                   st;
  logic                   unused_hi;

  always_comb begin
    shifted = do_shift ? (value >>> FRAC) : value;
    st      = sat_trunc(SAT_MAXW'(shifted), WIDTH, SAT != 0);
  end

  assign result    = st.val[WIDTH-1:0];
  assign flag_z    = (result == '0);
  assign flag_n    = result[WIDTH-1];
  assign flag_v    = st.ovf;
  assign unused_hi = ^st.val[SAT_MAXW-1:WIDTH];
endmodule

// File: rtl/alu_pipe.sv
// Two-stage signed ALU with MAC accumulator and valid/ready handshakes.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 0,
  parameter int GUARD = 8,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [OP_W-1:0]         op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    flag_z,
  output logic                    flag_n,
  output logic                    flag_v
);
  localparam int SUM_W  = WIDTH + 1;
  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = 2 * WIDTH + GUARD;

  logic en;

  logic                     s1_valid;
  logic [OP_W-1:0]          s1_op;
  logic signed [SUM_W-1:0]  s1_sum;
  logic signed [WIDTH-1:0]  s1_logic;
  logic signed [PROD_W-1:0] s1_prod;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [WIDTH-1:0]  logic_next;

  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  acc_new;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  sat_in;
  logic                     do_shift;
  logic signed [WIDTH-1:0]  sat_result;
  logic                     sat_z;
  logic                     sat_n;
  logic                     sat_v;

  // One enable for both stages: a stalled output freezes the whole pipe.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    sum_next = (op == OP_SUB) ? SUM_W'(a) - SUM_W'(b) : SUM_W'(a) + SUM_W'(b);
    case (op)
      OP_AND:  logic_next = a & b;
      OP_OR:   logic_next = a | b;
      default: logic_next = a ^ b;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_sum   <= '0;
      s1_logic <= '0;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op    <= op;
        s1_sum   <= sum_next;
        s1_logic <= logic_next;
        s1_prod  <= PROD_W'(a) * PROD_W'(b);
      end
    end
  end

  // MAC accumulates the unshifted product; only the reported value is shifted.
  always_comb begin
    acc_new  = acc_reg + ACC_W'(s1_prod);
    acc_next = acc_reg;
    sat_in   = ACC_W'(s1_sum);
    do_shift = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB: sat_in = ACC_W'(s1_sum);
      OP_AND, OP_OR, OP_XOR: sat_in = ACC_W'(s1_logic);
      OP_MUL: begin
        sat_in   = ACC_W'(s1_prod);
        do_shift = 1'b1;
      end
      OP_MAC: begin
        sat_in   = acc_new;
        do_shift = 1'b1;
        acc_next = acc_new;
      end
      default: begin
        sat_in   = acc_reg;
        do_shift = 1'b1;
        acc_next = '0;
      end
    endcase
  end

  alu_sat #(
    .IN_W (ACC_W),
    .WIDTH(WIDTH),
    .FRAC (FRAC),
    .SAT  (SAT)
  ) u_sat (
    .value   (sat_in),
    .do_shift(do_shift),
    .result  (sat_result),
    .flag_z  (sat_z),
    .flag_n  (sat_n),
    .flag_v  (sat_v)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      acc_reg   <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= sat_result;
        flag_z  <= sat_z;
        flag_n  <= sat_n;
        flag_v  <= sat_v;
        acc_reg <= acc_next;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three configurations share one stimulus stream and a scoreboard.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic rand_ready = 1'b0;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;
  logic [2:0] op = '0;

  logic [15:0] res_d [3];
  logic rdy_d [3];
  logic ov_d [3];
  logic z_d [3];
  logic n_d [3];
  logic v_d [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .FRAC(0), .GUARD(8), .SAT(1)) u0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_d[0]), .a(a), .b(b), .op(op),
    .out_valid(ov_d[0]), .out_ready(out_ready), .result(res_d[0]),
    .flag_z(z_d[0]), .flag_n(n_d[0]), .flag_v(v_d[0]));
  alu_pipe #(.WIDTH(16), .FRAC(0), .GUARD(8), .SAT(0)) u1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_d[1]), .a(a), .b(b), .op(op),
    .out_valid(ov_d[1]), .out_ready(out_ready), .result(res_d[1]),
    .flag_z(z_d[1]), .flag_n(n_d[1]), .flag_v(v_d[1]));
  alu_pipe #(.WIDTH(16), .FRAC(15), .GUARD(8), .SAT(1)) u2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_d[2]), .a(a), .b(b), .op(op),
    .out_valid(ov_d[2]), .out_ready(out_ready), .result(res_d[2]),
    .flag_z(z_d[2]), .flag_n(n_d[2]), .flag_v(v_d[2]));

  typedef struct {
    bit          chk;
    int          sel;
    logic [2:0]  op;
    int          a;
    int          b;
    int          res;
    bit          z;
    bit          n;
    bit          v;
  } vec_t;

  typedef struct packed {
    logic [2:0][15:0] r;
    logic [2:0]       z;
    logic [2:0]       n;
    logic [2:0]       v;
    logic             chk;
    logic [1:0]       sel;
    logic [15:0]      dres;
    logic             dz;
    logic             dn;
    logic             dv;
  } exp_t;

  exp_t   sb[$];
  longint acc_m [3];
  int     frac_m [3];
  bit     sat_m [3];
  vec_t   tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrapn(input longint v, input int nb);
    longint m;
    longint r;
    m = longint'(1) <<< nb;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Reference: exact integer arithmetic, then range-limit the reported value.
  function automatic void model(input int d, input logic [2:0] o,
                                input logic signed [15:0] x, input logic signed [15:0] y,
                                output logic [15:0] r, output logic z, output logic n, output logic v);
    longint p;
    longint full;
    logic [15:0] bits;
    p = longint'(x) * longint'(y);
    case (o)
      OP_ADD: full = longint'(x) + longint'(y);
      OP_SUB: full = longint'(x) - longint'(y);
      OP_AND: begin bits = x & y; full = longint'($signed(bits)); end
      OP_OR:  begin bits = x | y; full = longint'($signed(bits)); end
      OP_XOR: begin bits = x ^ y; full = longint'($signed(bits)); end
      OP_MUL: full = p >>> frac_m[d];
      OP_MAC: begin
        acc_m[d] = wrapn(acc_m[d] + p, 40);
        full = acc_m[d] >>> frac_m[d];
      end
      default: begin
        full = acc_m[d] >>> frac_m[d];
        acc_m[d] = 0;
      end
    endcase
    v = (full > 32767) || (full < -32768);
    if (v && sat_m[d]) full = (full > 0) ? 32767 : -32768;
    else full = wrapn(full, 16);
    r = full[15:0];
    z = (r == 16'd0);
    n = r[15];
  endfunction

  function automatic vec_t mk(input int sel, input logic [2:0] o, input int x, input int y,
                              input int r, input bit z, input bit n, input bit v);
    vec_t t;
    t.chk = 1'b1; t.sel = sel; t.op = o; t.a = x; t.b = y;
    t.res = r; t.z = z; t.n = n; t.v = v;
    return t;
  endfunction

  function automatic vec_t rnd(input logic [2:0] o, input int x, input int y);
    vec_t t;
    t = mk(0, o, x, y, 0, 1'b0, 1'b0, 1'b0);
    t.chk = 1'b0;
    return t;
  endfunction

  function automatic int pick_operand();
    case ($urandom_range(0, 4))
      0: return 32767;
      1: return -32768;
      2: return $urandom_range(0, 40) - 20;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Holds the beat until accepted; the expectation is queued at the accept edge.
  task automatic send(input vec_t t);
    int guard;
    bit done;
    exp_t e;
    logic [15:0] rr;
    logic zz, nn, vv;
    guard = 0;
    done = 1'b0;
    op = t.op; a = t.a[15:0]; b = t.b[15:0]; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (rdy_d[0]) begin
        for (int d = 0; d < 3; d++) begin
          model(d, t.op, a, b, rr, zz, nn, vv);
          e.r[d] = rr; e.z[d] = zz; e.n[d] = nn; e.v[d] = vv;
        end
        e.chk = t.chk; e.sel = t.sel[1:0]; e.dres = t.res[15:0];
        e.dz = t.z; e.dn = t.n; e.dv = t.v;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 100) begin
          check("accept_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && g < 60) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  // Scoreboard: one line per transferred beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && ov_d[0] && out_ready) begin
        if (sb.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          for (int d = 0; d < 3; d++) begin
            check($sformatf("valid_cfg%0d", d), ov_d[d], 32'd1);
            check($sformatf("result_cfg%0d", d), res_d[d], e.r[d]);
            check($sformatf("flag_z_cfg%0d", d), z_d[d], e.z[d]);
            check($sformatf("flag_n_cfg%0d", d), n_d[d], e.n[d]);
            check($sformatf("flag_v_cfg%0d", d), v_d[d], e.v[d]);
          end
          if (e.chk) begin
            check("dir_result", res_d[e.sel], e.dres);
            check("dir_z", z_d[e.sel], e.dz);
            check("dir_n", n_d[e.sel], e.dn);
            check("dir_v", v_d[e.sel], e.dv);
          end
          $display("beat: cfg0=%0d cfg1=%0d cfg2=%0d expected %0d/%0d/%0d",
                   $signed(res_d[0]), $signed(res_d[1]), $signed(res_d[2]),
                   $signed(e.r[0]), $signed(e.r[1]), $signed(e.r[2]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    frac_m[0] = 0;  frac_m[1] = 0;  frac_m[2] = 15;
    sat_m[0] = 1'b1; sat_m[1] = 1'b0; sat_m[2] = 1'b1;
    for (int d = 0; d < 3; d++) acc_m[d] = 0;

    tbl[0]  = mk(0, OP_SUB, 5, 5, 0, 1, 0, 0);
    tbl[1]  = mk(0, OP_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 0, 0, 0);
    tbl[2]  = mk(0, OP_ADD, 32767, 1, 32767, 0, 0, 1);
    tbl[3]  = mk(0, OP_SUB, -32768, 1, -32768, 0, 1, 1);
    tbl[4]  = mk(0, OP_MUL, 300, 300, 32767, 0, 0, 1);
    tbl[5]  = mk(1, OP_ADD, 32767, 1, -32768, 0, 1, 1);
    tbl[6]  = mk(0, OP_CLRACC, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(0, OP_MAC, 3, 4, 12, 0, 0, 0);
    tbl[8]  = mk(0, OP_MAC, 5, 6, 42, 0, 0, 0);
    tbl[9]  = mk(0, OP_MAC, -2, 7, 28, 0, 0, 0);
    tbl[10] = mk(0, OP_CLRACC, 0, 0, 28, 0, 0, 0);
    tbl[11] = mk(0, OP_MAC, 1, 1, 1, 0, 0, 0);
    tbl[12] = mk(2, OP_MUL, 16'h4000, 16'h4000, 16'h2000, 0, 0, 0);
    tbl[13] = mk(2, OP_MUL, -32768, -32768, 32767, 0, 0, 1);
    tbl[14] = mk(0, OP_AND, 16'hF0F0, 16'hFF00, -4096, 0, 1, 0);

    // Reset state is visible without any clock edge.
    #1 resetn = 1'b0;
    #1;
    check("rst_out_valid", ov_d[0], 32'd0);
    check("rst_result", res_d[0], 32'd0);
    check("rst_flags", {z_d[0], n_d[0], v_d[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", rdy_d[0], 32'd1);
    @(posedge clk);
    #1;

    // Latency: output appears in the second cycle after acceptance.
    send(mk(0, OP_ADD, 100, 23, 123, 0, 0, 0));
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1", ov_d[0], 32'd0);
    @(negedge clk);
    check("latency_cycle2", ov_d[0], 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) send(tbl[i]);
    drain();

    // Backpressure mid-stream, with MAC beats in flight during the stall.
    fork
      begin
        send(rnd(OP_CLRACC, 0, 0));
        send(mk(0, OP_MAC, 2, 3, 6, 0, 0, 0));
        send(mk(0, OP_MAC, 4, 5, 26, 0, 0, 0));
        send(mk(0, OP_MAC, -1, 6, 20, 0, 0, 0));
        for (int i = 4; i < 8; i++) send(mk(0, OP_ADD, i * 10, i, i * 11, 0, 0, 0));
        in_valid = 1'b0;
      end
      begin
        logic [15:0] hold;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        #1;
        check("stall_in_ready", rdy_d[0], 32'd0);
        hold = res_d[0];
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_valid", ov_d[0], 32'd1);
          check("stall_result", res_d[0], hold);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random gaps and random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(rnd(3'($urandom_range(0, 7)), pick_operand(), pick_operand()));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with two MAC beats in flight.
    send(rnd(OP_MAC, 100, 100));
    send(rnd(OP_MAC, 50, 50));
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("async_rst_valid_cfg%0d", d), ov_d[d], 32'd0);
      check($sformatf("async_rst_result_cfg%0d", d), res_d[d], 32'd0);
    end
    sb.delete();
    for (int d = 0; d < 3; d++) acc_m[d] = 0;
    repeat (2) @(negedge clk);
    check("rst_hold_valid", ov_d[0], 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("no_output_after_reset", ov_d[0], 32'd0);
    @(posedge clk);
    #1;
    send(mk(0, OP_CLRACC, 0, 0, 0, 1, 0, 0));
    send(mk(0, OP_MAC, 7, 8, 56, 0, 0, 0));
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
